// File: rtl/ercd16_v2_4_if.sv
// Operand/result handshake bundle for the ercd16_v2_4 16/8 divider.
// Optional trunc_k operand exists only when ERCD16_TRUNC_EN is defined.
interface ercd16_v2_4_if;
    logic        in_vld;
    logic        in_rdy;
    logic [15:0] dat_in_a;
    logic [7:0]  dat_in_b;
`ifdef ERCD16_TRUNC_EN
    logic [2:0]  trunc_k;
`endif
    logic        out_vld;
    logic        out_rdy;
    logic [7:0]  dat_o;
    logic [7:0]  rem_o;
    logic        dz_o;
    logic        ovf_o;

    modport slave (
        input  in_vld, dat_in_a, dat_in_b, out_rdy,
`ifdef ERCD16_TRUNC_EN
        input  trunc_k,
`endif
        output in_rdy, out_vld, dat_o, rem_o, dz_o, ovf_o
    );

    modport master (
        output in_vld, dat_in_a, dat_in_b, out_rdy,
`ifdef ERCD16_TRUNC_EN
        output trunc_k,
`endif
        input  in_rdy, out_vld, dat_o, rem_o, dz_o, ovf_o
    );
endinterface

// File: rtl/ercd16_v2_4.sv
// Sequential 16/8 unsigned restoring divider with valid/ready on both sides.
// ERCD16_TRUNC_EN adds trunc_k to skip the last k iterations (approximate result).
module ercd16_v2_4 #(
    parameter logic [7:0] DZ_QUO  = 8'hFF,
    parameter logic [7:0] OVF_QUO = 8'hFF
) (
    input  logic          clk,
    input  logic          rst_n,
    ercd16_v2_4_if.slave  bus
);

    localparam int unsigned B_W   = 8;
    localparam int unsigned CNT_W = 3;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_CALC = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [B_W-1:0]   r_q, r_d;
    logic [B_W-1:0]   q_q, q_d;
    logic [B_W-1:0]   b_q, b_d;
    logic [B_W-1:0]   dat_q, dat_d;
    logic [B_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [CNT_W-1:0] k_in;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic             in_rdy_q, in_rdy_d;
    logic             out_vld_q, out_vld_d;
    logic [B_W:0]     trial;

`ifdef ERCD16_TRUNC_EN
    assign k_in = bus.trunc_k;
`else
    assign k_in = '0;
`endif

    // Trial subtraction of the divisor from the shifted partial remainder
    assign trial = {r_q, q_q[B_W-1]} - {1'b0, b_q};

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        q_d       = q_q;
        b_d       = b_q;
        dat_d     = dat_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_vld && in_rdy_q) begin
                    dz_d  = 1'b0;
                    ovf_d = 1'b0;
                    if (bus.dat_in_b == '0) begin
                        state_d = S_DONE;
                        dz_d    = 1'b1;
                        dat_d   = DZ_QUO;
                        rem_d   = bus.dat_in_a[7:0];
                    end else if (bus.dat_in_a[15:8] >= bus.dat_in_b) begin
                        state_d = S_DONE;
                        ovf_d   = 1'b1;
                        dat_d   = OVF_QUO;
                        rem_d   = '0;
                    end else begin
                        state_d = S_CALC;
                        r_d     = bus.dat_in_a[15:8];
                        q_d     = bus.dat_in_a[7:0];
                        b_d     = bus.dat_in_b;
                        k_d     = k_in;
                        cnt_d   = CNT_W'(7) - k_in;
                    end
                end
            end
            S_CALC: begin
                if (!trial[B_W]) begin
                    r_d = trial[B_W-1:0];
                    q_d = {q_q[B_W-2:0], 1'b1};
                end else begin
                    r_d = {r_q[B_W-2:0], q_q[B_W-1]};
                    q_d = {q_q[B_W-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    // Left-align a truncated quotient; with k=0 this is the exact quotient
                    dat_d   = q_d << k_q;
                    rem_d   = r_d;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (bus.out_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_rdy_d  = (state_d == S_IDLE);
        out_vld_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            r_q       <= '0;
            q_q       <= '0;
            b_q       <= '0;
            dat_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            k_q       <= '0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            q_q       <= q_d;
            b_q       <= b_d;
            dat_q     <= dat_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
            in_rdy_q  <= in_rdy_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign bus.in_rdy  = in_rdy_q;
    assign bus.out_vld = out_vld_q;
    assign bus.dat_o   = dat_q;
    assign bus.rem_o   = rem_q;
    assign bus.dz_o    = dz_q;
    assign bus.ovf_o   = ovf_q;

endmodule

// File: tb/tb_ercd16_v2_4.sv
// Self-checking bench for ercd16_v2_4: directed corner cases plus randomized
// operands against an arithmetic (/, %) reference model.
module tb_ercd16_v2_4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ercd16_v2_4_if bus();

    ercd16_v2_4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected result; latency counts edges after the accepting edge
    function automatic void model(input logic [15:0] a, input logic [7:0] b, input int k,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dz, output logic ovf, output int lat);
        int a2;
        dz  = 1'b0;
        ovf = 1'b0;
        if (b == 8'd0) begin
            dz = 1'b1; q = 8'hFF; r = a[7:0]; lat = 0;
        end else if (a[15:8] >= b) begin
            ovf = 1'b1; q = 8'hFF; r = 8'h00; lat = 0;
        end else begin
            a2  = int'(a) >> k;
            q   = 8'((a2 / int'(b)) << k);
            r   = 8'(a2 % int'(b));
            lat = 8 - k;
        end
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input logic [2:0] k,
                          output int lat, output logic [7:0] q, output logic [7:0] r,
                          output logic dz, output logic ovf, output logic timed_out);
        int w = 0;
        while (!bus.in_rdy && w < 50) begin
            @(posedge clk); #1; w++;
        end
        bus.in_vld   = 1'b1;
        bus.dat_in_a = a;
        bus.dat_in_b = b;
`ifdef ERCD16_TRUNC_EN
        bus.trunc_k  = k;
`else
        if (k != 3'd0) $display("note: trunc_k ignored in this build");
`endif
        @(posedge clk); #1;
        bus.in_vld   = 1'b0;
        bus.dat_in_a = 16'($urandom);
        bus.dat_in_b = 8'($urandom);
        lat = 0;
        while (!bus.out_vld && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        timed_out = !bus.out_vld;
        q   = bus.dat_o;
        r   = bus.rem_o;
        dz  = bus.dz_o;
        ovf = bus.ovf_o;
    endtask

    task automatic release_result();
        bus.out_rdy = 1'b1;
        @(posedge clk); #1;
        bus.out_rdy = 1'b0;
    endtask

    // One directed operation: latency, result fields, then idle after handshake
    task automatic check_op(input string name, input logic [15:0] a, input logic [7:0] b,
                            input logic [2:0] k);
        int lat, elat;
        logic [7:0] q, r, eq, er;
        logic dz, ovf, edz, eovf, to;
        model(a, b, int'(k), eq, er, edz, eovf, elat);
        run_op(a, b, k, lat, q, r, dz, ovf, to);
        tests_run++;
        if ({to, lat} !== {1'b0, elat}) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d (timeout=%0b) want %0d", name, lat, to, elat);
        end
        tests_run++;
        if ({q, r, dz, ovf} !== {eq, er, edz, eovf}) begin
            tests_failed++;
            $display("FAIL %s result: got q=%h r=%h dz=%b ovf=%b want q=%h r=%h dz=%b ovf=%b",
                     name, q, r, dz, ovf, eq, er, edz, eovf);
        end
        release_result();
        tests_run++;
        if ({bus.in_rdy, bus.out_vld} !== 2'b10) begin
            tests_failed++;
            $display("FAIL %s return_idle: got in_rdy=%b out_vld=%b want 1 0",
                     name, bus.in_rdy, bus.out_vld);
        end
    endtask

    task automatic test_reset();
        bus.in_vld = 1'b0; bus.out_rdy = 1'b0;
        bus.dat_in_a = '0; bus.dat_in_b = '0;
`ifdef ERCD16_TRUNC_EN
        bus.trunc_k = '0;
`endif
        rst_n = 1'b0;
        #17;
        tests_run++;
        if ({bus.in_rdy, bus.out_vld, bus.dat_o, bus.rem_o, bus.dz_o, bus.ovf_o} !== {2'b10, 18'd0}) begin
            tests_failed++;
            $display("FAIL reset_state: got rdy=%b vld=%b q=%h r=%h dz=%b ovf=%b want 1 0 00 00 0 0",
                     bus.in_rdy, bus.out_vld, bus.dat_o, bus.rem_o, bus.dz_o, bus.ovf_o);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.in_rdy, bus.out_vld, bus.dat_o, bus.rem_o, bus.dz_o, bus.ovf_o} !== {2'b10, 18'd0}) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got rdy=%b vld=%b q=%h r=%h want 1 0 00 00",
                     bus.in_rdy, bus.out_vld, bus.dat_o, bus.rem_o);
        end
    endtask

    task automatic test_exact();
        check_op("div_1000_7", 16'd1000, 8'd7, 3'd0);
        check_op("div_max_nonovf", 16'hFEFF, 8'hFF, 3'd0);
    endtask

    task automatic test_div_zero();
        check_op("div_zero", 16'h1234, 8'd0, 3'd0);
    endtask

    task automatic test_overflow();
        check_op("overflow", 16'hFF00, 8'h80, 3'd0);
        check_op("after_overflow", 16'd1000, 8'd7, 3'd0);
    endtask

    task automatic test_backpressure();
        int lat;
        logic [7:0] q, r;
        logic dz, ovf, to;
        run_op(16'd1000, 8'd7, 3'd0, lat, q, r, dz, ovf, to);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({bus.in_rdy, bus.out_vld, bus.dat_o, bus.rem_o, bus.dz_o, bus.ovf_o} !==
                {2'b01, 8'd142, 8'd6, 2'b00}) begin
                tests_failed++;
                $display("FAIL backpressure_hold[%0d]: got rdy=%b vld=%b q=%0d r=%0d want 0 1 142 6",
                         i, bus.in_rdy, bus.out_vld, bus.dat_o, bus.rem_o);
            end
        end
        release_result();
    endtask

    task automatic test_reset_mid_calc();
        bit stale = 1'b0;
        bus.in_vld = 1'b1; bus.dat_in_a = 16'd1000; bus.dat_in_b = 8'd7;
        @(posedge clk); #1;
        bus.in_vld = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.in_rdy, bus.out_vld, bus.dat_o, bus.rem_o, bus.dz_o, bus.ovf_o} !== {2'b10, 18'd0}) begin
            tests_failed++;
            $display("FAIL reset_mid_calc: got rdy=%b vld=%b q=%h r=%h want 1 0 00 00",
                     bus.in_rdy, bus.out_vld, bus.dat_o, bus.rem_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.out_vld) stale = 1'b1;
        end
        tests_run++;
        if ({stale, bus.in_rdy} !== 2'b01) begin
            tests_failed++;
            $display("FAIL no_stale_result: got stale_vld=%b in_rdy=%b want 0 1", stale, bus.in_rdy);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [7:0]  b;
        logic [2:0]  k;
        for (int i = 0; i < 150; i++) begin
            a = 16'($urandom);
            b = 8'($urandom_range(0, 255));
            if (b != 8'd0 && $urandom_range(0, 3) != 0) a[15:8] = 8'($urandom % b);
            if ($urandom_range(0, 15) == 0) b = 8'd0;
`ifdef ERCD16_TRUNC_EN
            k = 3'($urandom_range(0, 7));
`else
            k = 3'd0;
`endif
            check_op($sformatf("random_%0d", i), a, b, k);
        end
    endtask

`ifdef ERCD16_TRUNC_EN
    task automatic test_trunc();
        check_op("trunc_k3", 16'd1000, 8'd7, 3'd3);
    endtask
`endif

    initial begin
        test_reset();
        test_exact();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_reset_mid_calc();
        test_random();
`ifdef ERCD16_TRUNC_EN
        test_trunc();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
